// File: rtl/coin_pkg.sv
// Shared types and constants for the coin acceptor front end and its
// downstream consumer.
package coin_pkg;

   typedef enum logic [1:0] {
      COIN_NICKEL,
      COIN_DIME,
      COIN_QUARTER
   } coin_t;

   typedef enum logic [1:0] {
      IDLE,
      EMIT,
      GAP
   } state_t;

   localparam int NUM_COINS     = 3;
   localparam int CENTS_NICKEL  = 5;
   localparam int CENTS_DIME    = 10;
   localparam int CENTS_QUARTER = 25;

   // Bit order matches {quarter, dime, nickel}.
   function automatic logic [2:0] coin_onehot(input coin_t c);
      return 3'b001 << c;
   endfunction

endpackage

// File: rtl/coin_debounce.sv
// One coin sensor line: two-flop synchronizer, down-counting debouncer and
// a registered one-cycle pulse on each accepted rising level.
module coin_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic i_raw,
   output logic o_rise
);

   localparam int             CW     = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0]  RELOAD = CW'(DEBOUNCE_CYCLES - 1);

   logic          r_meta;
   logic          r_sync;
   logic          r_deb;
   logic          r_rise;
   logic [CW-1:0] r_cnt;

   // The counter reloads on any cycle where the synchronized level agrees
   // with the accepted level, so a gap in the mismatch restarts the count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
         r_deb  <= 1'b0;
         r_rise <= 1'b0;
         r_cnt  <= RELOAD;
      end else begin
         r_meta <= i_raw;
         r_sync <= r_meta;
         r_rise <= 1'b0;
         if (r_sync == r_deb) begin
            r_cnt <= RELOAD;
         end else if (r_cnt == '0) begin
            r_deb  <= r_sync;
            r_rise <= r_sync;
            r_cnt  <= RELOAD;
         end else begin
            r_cnt <= r_cnt - CW'(1);
         end
      end
   end

   assign o_rise = r_rise;

endmodule

// File: rtl/coin_acceptor.sv
// Coin sensor front end: debounces three raw lines, queues coin events and
// replays them to the vending machine as isolated one-cycle pulses.
//
// state | meaning
// IDLE  | waiting for a queued coin; pops the head and raises its pulse
// EMIT  | pulse is high this cycle; drop it next edge
// GAP   | mandatory idle cycle between pulses
import coin_pkg::*;

module coin_acceptor #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int QUEUE_DEPTH     = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic nickel_raw,
   input  logic dime_raw,
   input  logic quarter_raw,
   output logic nickel,
   output logic dime,
   output logic quarter,
   output logic busy,
   output logic overflow
);

   localparam int CNTW = $clog2(QUEUE_DEPTH + 1);

   logic [2:0]      w_rise;
   logic [2:0]      w_raw;

   coin_t           r_mem [QUEUE_DEPTH];
   coin_t           w_mem_n [QUEUE_DEPTH];
   logic [CNTW-1:0] r_count;
   logic [CNTW-1:0] w_count_n;
   logic [CNTW-1:0] w_free;
   logic [CNTW-1:0] w_base;
   logic [CNTW-1:0] w_nacc;
   logic            w_pop;
   logic            w_drop;
   logic            r_overflow;

   state_t          r_state;
   logic [2:0]      r_pulse;

   assign w_raw[COIN_NICKEL]  = nickel_raw;
   assign w_raw[COIN_DIME]    = dime_raw;
   assign w_raw[COIN_QUARTER] = quarter_raw;

   for (genvar g = 0; g < NUM_COINS; g++) begin : g_line
      coin_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk   (clk),
         .reset (reset),
         .i_raw (w_raw[g]),
         .o_rise(w_rise[g])
      );
   end

   assign w_pop = (r_state == IDLE) && (r_count != '0);

   // Shift-register FIFO: entry 0 is the head. Same-cycle events land in
   // quarter, dime, nickel order behind whatever survives this cycle's pop;
   // free space is judged before the pop so a full queue never accepts.
   always_comb begin
      w_mem_n = r_mem;
      w_free  = CNTW'(QUEUE_DEPTH) - r_count;
      w_base  = r_count - CNTW'(w_pop);
      w_nacc  = '0;
      w_drop  = 1'b0;
      if (w_pop) begin
         for (int i = 0; i < QUEUE_DEPTH - 1; i++) begin
            w_mem_n[i] = r_mem[i+1];
         end
      end
      for (int k = NUM_COINS - 1; k >= 0; k--) begin
         if (w_rise[k]) begin
            if (w_nacc < w_free) begin
               for (int i = 0; i < QUEUE_DEPTH; i++) begin
                  if (CNTW'(i) == (w_base + w_nacc)) begin
                     w_mem_n[i] = coin_t'(k[1:0]);
                  end
               end
               w_nacc = w_nacc + CNTW'(1);
            end else begin
               w_drop = 1'b1;
            end
         end
      end
      w_count_n = w_base + w_nacc;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < QUEUE_DEPTH; i++) begin
            r_mem[i] <= COIN_NICKEL;
         end
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_mem      <= w_mem_n;
         r_count    <= w_count_n;
         r_overflow <= w_drop;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_pulse <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_pop) begin
                  r_pulse <= coin_onehot(r_mem[0]);
                  r_state <= EMIT;
               end
            end
            EMIT: begin
               r_pulse <= '0;
               r_state <= GAP;
            end
            GAP: begin
               r_state <= IDLE;
            end
            default: begin
               r_pulse <= '0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign nickel   = r_pulse[COIN_NICKEL];
   assign dime     = r_pulse[COIN_DIME];
   assign quarter  = r_pulse[COIN_QUARTER];
   assign overflow = r_overflow;
   assign busy     = (r_count != '0) || (r_state != IDLE);

endmodule

// File: doc/coin_acceptor.md
# coin_acceptor

- Front-end stage that sits directly upstream of `vendingMachine`.
- Takes the three raw, asynchronous coin-sensor lines and processes each one:
  - synchronizes it;
  - debounces it;
  - turns each debounced rising edge into one coin event.
- Coin events are queued and replayed to `vendingMachine` as clean pulses:
  - each pulse is one cycle wide;
  - only one coin line is high in any cycle;
  - every pulse is followed by at least one idle cycle.
- Coins arriving in the same cycle are therefore serialized, not merged.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive cycles a synchronized level must hold before it is accepted; legal range ≥1.
- `QUEUE_DEPTH`, default 4: coin-event FIFO entries; legal range ≥2.

Ports:
- `clk`  in  1  single system clock, rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `nickel_raw`  in  1  raw nickel sensor, asynchronous to `clk`.
- `dime_raw`  in  1  raw dime sensor, asynchronous.
- `quarter_raw`  in  1  raw quarter sensor, asynchronous.
- `nickel`  out  1  one-cycle coin pulse to `vendingMachine`.
- `dime`  out  1  one-cycle coin pulse.
- `quarter`  out  1  one-cycle coin pulse.
- `busy`  out  1  high while the queue is non-empty or the output FSM is not IDLE.
- `overflow`  out  1  one-cycle pulse when at least one event is dropped.

## Operation
- **Reset:**
  - All outputs are 0, driven asynchronously.
  - Synchronizers and debounced states are cleared to 0; the FIFO is emptied; the FSM goes to IDLE.
  - A raw line that is high when reset is released counts as one coin after normal latency.
- **Per line:**
  - Two-flop synchronizer produces `s`.
  - Debounced state `d` takes the value of `s` once `s != d` has held on `DEBOUNCE_CYCLES` consecutive edges.
  - Any mismatch gap restarts the count.
  - A 0→1 transition of `d` generates one event.
  - A 1→0 transition generates nothing.
- **Enqueue:**
  - Events from the same cycle are written in order quarter, dime, nickel, up to the free slots (`QUEUE_DEPTH - count`, counted before any pop that cycle).
  - Surplus events are dropped and `overflow` pulses.
  - A push and a pop may happen in the same cycle.
- **Output FSM:**
  - IDLE: if the FIFO is non-empty, pop the head, register the matching output high, go to EMIT.
  - EMIT: all outputs go low; go to GAP.
  - GAP: go to IDLE.
  - Pulses are exactly one cycle wide, and pulse starts are at least 3 edges apart.
  - Outputs are registered with no combinational path from any input.

## Timing
- A raw rise that is stable from sampling edge 1 produces its pulse high after edge `DEBOUNCE_CYCLES + 4`. This assumes the FIFO is empty and the FSM is IDLE. Breakdown:
  - edges 1–2: synchronizer;
  - edges 3 to `DEBOUNCE_CYCLES + 2`: debounce; `d` rises;
  - next edge: FIFO write;
  - next edge: pop and pulse.
- With default parameters the latency is 8 edges.
- A pulse in progress cannot be aborted except by `reset`.
- A glitch shorter than `DEBOUNCE_CYCLES` synchronized cycles produces no event.
- `overflow` is asserted in the cycle after the drop, at the FIFO-write edge.

## Structure
- Package `coin_pkg`:
  - `typedef enum logic [1:0] coin_t {COIN_NICKEL, COIN_DIME, COIN_QUARTER}`;
  - FSM state enum `{IDLE, EMIT, GAP}`;
  - cent-value constants 5, 10 and 25 for downstream use.
- Sub-module `coin_debounce`:
  - contains the synchronizer, the debounce counter of `$clog2(DEBOUNCE_CYCLES+1)` bits, and the rise detect;
  - is instantiated once per coin line.
- The top level holds the multi-write FIFO of `coin_t` entries and the output FSM.

## Test plan
Defaults apply unless a scenario states otherwise.
1. **Reset:** hold `reset` high for 3 cycles with raw lines low. All outputs stay 0 during reset and for 20 cycles after release.
2. **Single quarter:** hold `quarter_raw` high for 10 cycles. `quarter` is high for exactly one cycle, after edge 8. No pulse follows the later fall. `busy` drops 2 cycles after the pulse.
3. **Glitch rejection:** hold `dime_raw` high for 3 cycles. No output pulse, no `busy`.
4. **Simultaneous coins:** all three raw lines rise in the same cycle. Pulses appear as `quarter` after edge 8, `dime` after edge 11, `nickel` after edge 14. No two outputs are ever high together.
5. **Overflow** (`DEBOUNCE_CYCLES=1`, `QUEUE_DEPTH=2`): all three lines rise together.
   - Quarter and dime are emitted.
   - Nickel is dropped.
   - `overflow` is high for exactly one cycle.
6. **Reset mid-operation:** assert `reset` while 2 events are queued. Outputs drop to 0 immediately. After release with raw lines low, no pulse ever appears.
